frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/frame_capture_ctrl.sv | 129 ++++++++++++
 tb/tb_frame_capture_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on command, waits for a frame-start sync and
// streams one RGB565 frame (or back-to-back frames) into a linear frame buffer.
module frame_capture_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_continuous,
  input  logic              cmd_abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              img_valid,
  input  logic              img_sync,
  input  logic [15:0]       img_data,
  output logic              img_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LINE_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, FLUSH} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] pix_addr;
  logic              cont_q;
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              accept, last_pixel, final_hs, short_frame, frame_start;

  assign accept      = (state == CAPTURE) && img_valid && img_ready;
  assign last_pixel  = accept && (col_cnt == COL_LAST) && (line_cnt == LINE_LAST);
  assign final_hs    = (state == FLUSH) && wr_valid && wr_ready;
  assign short_frame = (state == CAPTURE) && img_sync;
  assign frame_start = ((state == WAIT_SYNC) && img_sync) || short_frame;
  assign busy        = (state != IDLE);

  always_comb begin
    img_ready = 1'b0;
    case (state)
      IDLE, WAIT_SYNC: img_ready = 1'b1;
      CAPTURE:         img_ready = !wr_valid || wr_ready;
      default:         img_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Abort wins over every other request; a short frame keeps us in CAPTURE.
  always_comb begin
    state_next = state;
    if (cmd_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (cmd_start) state_next = WAIT_SYNC;
        WAIT_SYNC: if (img_sync) state_next = CAPTURE;
        CAPTURE:   if (!img_sync && last_pixel) state_next = FLUSH;
        FLUSH:     if (final_hs) state_next = cont_q ? WAIT_SYNC : IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // pix_addr tracks base + line*IMG_W + col incrementally, so no multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      cont_q      <= 1'b0;
      pix_addr    <= '0;
      col_cnt     <= '0;
      line_cnt    <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= final_hs && !cmd_abort;
      frame_err  <= short_frame && !cmd_abort;
      if (final_hs && !cmd_abort) frame_count <= frame_count + 8'd1;
      if ((state == IDLE) && cmd_start && !cmd_abort) begin
        base_q <= base_addr;
        cont_q <= cmd_continuous;
      end
      if (!cmd_abort) begin
        if (frame_start) begin
          col_cnt  <= '0;
          line_cnt <= '0;
          pix_addr <= base_q;
        end else if (accept) begin
          pix_addr <= pix_addr + ADDR_W'(1);
          if (col_cnt == COL_LAST) begin
            col_cnt  <= '0;
            line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LINE_W'(1);
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
      end
      if (cmd_abort) begin
        wr_valid <= 1'b0;
      end else if (accept && !img_sync) begin
        wr_valid <= 1'b1;
        wr_addr  <= pix_addr;
        wr_data  <= img_data;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized scoreboard bench for frame_capture_ctrl (4x2 image, 12-bit addresses);
// a behavioural frame model predicts writes, a monitor checks them as they appear.
module tb_frame_capture_ctrl;

  localparam int W = 4;
  localparam int H = 2;
  localparam int AW = 12;
  localparam int FRAME_PIX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0;
  logic          cmd_continuous = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          img_valid = 1'b0;
  logic          img_sync = 1'b0;
  logic [15:0]   img_data = '0;
  logic          img_ready;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ready = 1'b1;
  logic          busy, frame_done, frame_err;
  logic [7:0]    frame_count;

  frame_capture_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_continuous(cmd_continuous),
    .cmd_abort(cmd_abort), .base_addr(base_addr), .img_valid(img_valid),
    .img_sync(img_sync), .img_data(img_data), .img_ready(img_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_WAIT, M_CAP, M_FLUSH} mstate_t;

  mstate_t        m_state = M_IDLE;
  logic [AW-1:0]  m_base = '0;
  logic           m_cont = 1'b0;
  int             m_idx = 0;
  int             exp_done = 0, exp_err = 0;
  int             exp_count = 0;
  logic [AW+15:0] exp_q[$];

  int   checks = 0, errors = 0;
  int   done_seen = 0, err_seen = 0;
  int   stall_cnt = 0;
  bit   bp_random = 1'b0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_data;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the k-th pixel after a sync lands at (base + k) mod 2^AW.
  task automatic model_pixel(input logic [15:0] d);
    logic [AW-1:0] a;
    if (m_state == M_CAP) begin
      a = AW'((int'(m_base) + m_idx) % (1 << AW));
      exp_q.push_back({a, d});
      m_idx++;
      if (m_idx == FRAME_PIX) begin
        m_state = M_FLUSH;
        exp_done++;
        exp_count = (exp_count + 1) % 256;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_start = 1'b0; cmd_abort = 1'b0; img_valid = 1'b0; img_sync = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_state = M_IDLE; m_idx = 0; m_base = '0; m_cont = 1'b0;
    exp_done = 0; exp_err = 0; exp_count = 0;
    done_seen = 0; err_seen = 0;
  endtask

  task automatic start_cmd(input logic [AW-1:0] b, input logic c);
    cmd_start = 1'b1; base_addr = b; cmd_continuous = c;
    if (m_state == M_IDLE) begin
      m_base = b; m_cont = c; m_state = M_WAIT;
    end
    tick();
    cmd_start = 1'b0;
    base_addr = AW'($urandom);
  endtask

  task automatic send_sync();
    img_sync = 1'b1;
    if (m_state == M_CAP) exp_err++;
    if (m_state == M_WAIT || m_state == M_CAP) begin
      m_state = M_CAP; m_idx = 0;
    end
    tick();
    img_sync = 1'b0;
  endtask

  // Offers n pixels with random idle gaps; the model sees only accepted ones.
  task automatic applyStimulus(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        img_valid = 1'b0;
        tick();
      end
      img_valid = 1'b1;
      img_data = 16'($urandom);
      acc = 1'b0;
      for (int w = 0; w < 200 && !acc; w++) begin
        @(negedge clk);
        acc = img_ready;
        if (acc) model_pixel(img_data);
        tick();
      end
      if (!acc) checkOutput("pixel accept timeout", img_ready, 1);
    end
    img_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_seen;
    for (int w = 0; w < 300 && done_seen == start; w++) tick();
    if (done_seen == start) checkOutput("frame_done timeout", done_seen - start, 1);
    if (m_state == M_FLUSH) m_state = m_cont ? M_WAIT : M_IDLE;
    checkOutput("scoreboard drained at frame end", exp_q.size(), 0);
  endtask

  task automatic abort_cmd();
    cmd_abort = 1'b1; cmd_start = 1'b1; img_sync = 1'b1;
    tick();
    cmd_abort = 1'b0; cmd_start = 1'b0; img_sync = 1'b0;
    m_state = M_IDLE;
    exp_q.delete();
  endtask

  // Write-channel driver: forced stalls first, then random or steady readiness.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        wr_ready = 1'b0;
        stall_cnt--;
      end else if (bp_random) begin
        wr_ready = ($urandom_range(0, 2) != 0);
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every write handshake and checks stalls.
  initial begin
    logic [AW+15:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stalled wr_valid held", wr_valid, 1);
          checkOutput("stalled wr_addr held", wr_addr, prev_addr);
          checkOutput("stalled wr_data held", wr_data, prev_data);
        end
        if (wr_valid && !wr_ready) checkOutput("img_ready while write stalled", img_ready, 0);
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard entries at write", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("write addr", wr_addr, e[AW+15:16]);
            checkOutput("write data", wr_data, e[15:0]);
          end
        end
        if (frame_done) done_seen++;
        if (frame_err) err_seen++;
        prev_stall = wr_valid && !wr_ready && !cmd_abort;
        prev_addr = wr_addr;
        prev_data = wr_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    do_reset();
    $display("[TB] reset state");
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wr_valid", wr_valid, 0);
    checkOutput("reset wr_addr", wr_addr, 0);
    checkOutput("reset wr_data", wr_data, 0);
    checkOutput("reset frame_count", frame_count, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset img_ready", img_ready, 1);

    $display("[TB] single shot");
    applyStimulus(2);
    start_cmd(12'h100, 1'b0);
    checkOutput("busy after start", busy, 1);
    send_sync();
    applyStimulus(FRAME_PIX);
    wait_done();
    checkOutput("single frame_count", frame_count, exp_count);
    checkOutput("single frame_done pulses", done_seen, exp_done);
    checkOutput("single busy after done", busy, 0);
    send_sync();
    applyStimulus(2);
    checkOutput("idle writes ignored", exp_q.size(), 0);

    $display("[TB] back-pressure");
    do_reset();
    start_cmd(12'h200, 1'b0);
    send_sync();
    applyStimulus(3);
    stall_cnt = 3;
    applyStimulus(FRAME_PIX - 3);
    wait_done();
    checkOutput("bp frame_done pulses", done_seen, exp_done);

    $display("[TB] short frame");
    do_reset();
    start_cmd(12'h300, 1'b0);
    send_sync();
    applyStimulus(5);
    send_sync();
    applyStimulus(FRAME_PIX);
    wait_done();
    checkOutput("short frame_err pulses", err_seen, exp_err);
    checkOutput("short frame_done pulses", done_seen, exp_done);
    checkOutput("short frame_count", frame_count, exp_count);

    $display("[TB] address wrap");
    do_reset();
    start_cmd(12'hFFE, 1'b0);
    send_sync();
    applyStimulus(FRAME_PIX);
    wait_done();
    checkOutput("wrap frame_count", frame_count, exp_count);

    $display("[TB] abort");
    do_reset();
    start_cmd(12'h040, 1'b0);
    send_sync();
    applyStimulus(3);
    abort_cmd();
    checkOutput("abort busy", busy, 0);
    checkOutput("abort wr_valid", wr_valid, 0);
    checkOutput("abort img_ready", img_ready, 1);
    checkOutput("abort frame_count", frame_count, exp_count);
    tick();
    checkOutput("abort frame_err pulses", err_seen, 0);
    checkOutput("abort frame_done pulses", done_seen, 0);
    applyStimulus(3);

    $display("[TB] continuous with random back-pressure");
    do_reset();
    bp_random = 1'b1;
    start_cmd(AW'($urandom), 1'b1);
    for (int f = 0; f < 3; f++) begin
      send_sync();
      applyStimulus(FRAME_PIX);
      wait_done();
      checkOutput("continuous busy", busy, 1);
      applyStimulus(2);
    end
    checkOutput("continuous frame_count", frame_count, exp_count);
    checkOutput("continuous frame_done pulses", done_seen, exp_done);
    bp_random = 1'b0;
    abort_cmd();
    checkOutput("continuous busy after abort", busy, 0);

    $display("[TB] reset mid-write");
    start_cmd(12'h500, 1'b0);
    send_sync();
    stall_cnt = 10;
    applyStimulus(1);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midreset wr_valid", wr_valid, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset frame_count", frame_count, 0);
    checkOutput("midreset wr_addr", wr_addr, 0);
    checkOutput("midreset img_ready", img_ready, 1);
    stall_cnt = 0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
